memory_banked: RTL

MEMORY_BANKED -- requirements
Module: memory_banked

---
 rtl/memory_banked_pkg.sv | 18 +
 rtl/memory_banked_dm_bank.sv | 25 ++
 rtl/memory_banked.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/memory_banked_pkg.sv
// Shared types for the banked fetch/data memory: FSM state encoding and a log2 helper.
// No logic, no latency, no flow control.
// Imported by memory_banked and its bank sub-module.
package memory_banked_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } mem_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/memory_banked_dm_bank.sv
// One data-memory bank: 1R/1W synchronous array with a registered read port.
// Read data lands one edge after rd_en; a same-edge write is not visible to that read.
// No backpressure: a write or read is performed on every edge its enable is high.
module dm_bank #(
   parameter int WIDTH = 16,
   parameter int ROW_W = 7,
   parameter int DEPTH = 128
) (
   input  logic             clk_fetch,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_en,
   input  logic [ROW_W-1:0] rd_row,
   output logic [WIDTH-1:0] rd_dat
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_fetch) begin
      if (wr_en) mem[wr_row] <= wr_dat;
      if (rd_en) rd_dat <= mem[rd_row];
   end

endmodule

// File: rtl/memory_banked.sv
// Program memory plus banked data memory that zero-fills itself after reset before accepting accesses.
// Reads: request sampled at edge N, data and valid presented after edge N+1; writes commit one edge later via a pending register.
// No backpressure: DM accesses during initialisation are dropped and flagged on acc_err.
module memory_banked
   import memory_banked_pkg::*;
#(
   parameter int PMA_SIZE = 8,
   parameter int PMD_SIZE = 32,
   parameter int DMA_SIZE = 8,
   parameter int DMD_SIZE = 16,
   parameter int DM_BANKS = 2
) (
   input  logic                clk_fetch,
   input  logic                reset,
   input  logic                ps_pm_cslt,
   input  logic                ps_pm_wrb,
   input  logic [PMA_SIZE-1:0] ps_pm_add,
   input  logic [PMD_SIZE-1:0] ps_pm_wdata,
   output logic [PMD_SIZE-1:0] pm_ps_op,
   output logic                pm_ps_valid,
   input  logic                ps_dm_cslt,
   input  logic                ps_dm_wrb,
   input  logic [DMA_SIZE-1:0] dg_dm_add,
   input  logic [DMD_SIZE-1:0] bc_dt,
   output logic [DMD_SIZE-1:0] dm_bc_dt,
   output logic                dm_bc_valid,
   output logic                mem_ready,
   output logic                acc_err
);

   localparam int BANK_W = clog2(DM_BANKS);
   localparam int BSEL_W = (BANK_W > 0) ? BANK_W : 1;
   localparam int ROW_W  = (DMA_SIZE > BANK_W) ? DMA_SIZE - BANK_W : 1;
   localparam int ROWS   = (2 ** DMA_SIZE) / DM_BANKS;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   function automatic logic [BSEL_W-1:0] bank_of(input logic [DMA_SIZE-1:0] a);
      logic [DMA_SIZE-1:0] m;
      m = a & DMA_SIZE'(DM_BANKS - 1);
      return m[BSEL_W-1:0];
   endfunction

   function automatic logic [ROW_W-1:0] row_of(input logic [DMA_SIZE-1:0] a);
      logic [DMA_SIZE-1:0] m;
      m = a >> BANK_W;
      return m[ROW_W-1:0];
   endfunction

   mem_state_t          state_q, state_d;
   logic                clr_en;
   logic [ROW_W-1:0]    row_cnt;
   logic                dm_rd, dm_wr;
   logic                pend_vld;
   logic [DMA_SIZE-1:0] pend_add;
   logic [DMD_SIZE-1:0] pend_dat;
   logic                rd_vld_q, byp_q;
   logic [BSEL_W-1:0]   rd_bank_q;
   logic [DMD_SIZE-1:0] byp_dat_q;
   logic [DMD_SIZE-1:0] bank_rd [DM_BANKS];

   always_ff @(posedge clk_fetch or negedge reset) begin
      if (!reset) state_q <= ST_INIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      clr_en  = 1'b0;
      case (state_q)
         ST_INIT: begin
            clr_en = 1'b1;
            if (row_cnt == LAST_ROW) state_d = ST_RUN;
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk_fetch or negedge reset) begin
      if (!reset)      row_cnt <= '0;
      else if (clr_en) row_cnt <= row_cnt + 1'b1;
   end

   assign mem_ready = (state_q == ST_RUN);
   assign dm_rd     = ps_dm_cslt && !ps_dm_wrb && (state_q == ST_RUN);
   assign dm_wr     = ps_dm_cslt &&  ps_dm_wrb && (state_q == ST_RUN);

   always_ff @(posedge clk_fetch or negedge reset) begin
      if (!reset)                                       acc_err <= 1'b0;
      else if (ps_dm_cslt && (state_q == ST_INIT))      acc_err <= 1'b1;
   end

   // The pending entry always drains on the next edge, so a newer write simply replaces it.
   always_ff @(posedge clk_fetch or negedge reset) begin
      if (!reset) begin
         pend_vld <= 1'b0;
         pend_add <= '0;
         pend_dat <= '0;
      end else begin
         pend_vld <= dm_wr;
         if (dm_wr) begin
            pend_add <= dg_dm_add;
            pend_dat <= bc_dt;
         end
      end
   end

   for (genvar b = 0; b < DM_BANKS; b++) begin : g_bank
      logic                wr_en;
      logic [ROW_W-1:0]    wr_row;
      logic [DMD_SIZE-1:0] wr_dat;

      assign wr_en  = clr_en || (pend_vld && (bank_of(pend_add) == BSEL_W'(b)));
      assign wr_row = clr_en ? row_cnt : row_of(pend_add);
      assign wr_dat = clr_en ? '0 : pend_dat;

      dm_bank #(
         .WIDTH (DMD_SIZE),
         .ROW_W (ROW_W),
         .DEPTH (ROWS)
      ) u_bank (
         .clk_fetch (clk_fetch),
         .wr_en     (wr_en),
         .wr_row    (wr_row),
         .wr_dat    (wr_dat),
         .rd_en     (dm_rd),
         .rd_row    (row_of(dg_dm_add)),
         .rd_dat    (bank_rd[b])
      );
   end

   // The array read races the pending commit on the same edge, so the pending word is captured for bypass.
   always_ff @(posedge clk_fetch or negedge reset) begin
      if (!reset) begin
         rd_vld_q    <= 1'b0;
         rd_bank_q   <= '0;
         byp_q       <= 1'b0;
         byp_dat_q   <= '0;
         dm_bc_valid <= 1'b0;
         dm_bc_dt    <= '0;
      end else begin
         rd_vld_q    <= dm_rd;
         dm_bc_valid <= rd_vld_q;
         if (dm_rd) begin
            rd_bank_q <= bank_of(dg_dm_add);
            byp_q     <= pend_vld && (pend_add == dg_dm_add);
            byp_dat_q <= pend_dat;
         end
         if (rd_vld_q) dm_bc_dt <= byp_q ? byp_dat_q : bank_rd[rd_bank_q];
      end
   end

   logic [PMD_SIZE-1:0] pm_mem [2 ** PMA_SIZE];
   logic [PMD_SIZE-1:0] pm_rd_dat;
   logic                pm_rd_vld;

   always_ff @(posedge clk_fetch) begin
      if (ps_pm_cslt &&  ps_pm_wrb) pm_mem[ps_pm_add] <= ps_pm_wdata;
      if (ps_pm_cslt && !ps_pm_wrb) pm_rd_dat <= pm_mem[ps_pm_add];
   end

   always_ff @(posedge clk_fetch or negedge reset) begin
      if (!reset) begin
         pm_rd_vld   <= 1'b0;
         pm_ps_valid <= 1'b0;
         pm_ps_op    <= '0;
      end else begin
         pm_rd_vld   <= ps_pm_cslt && !ps_pm_wrb;
         pm_ps_valid <= pm_rd_vld;
         if (pm_rd_vld) pm_ps_op <= pm_rd_dat;
      end
   end

endmodule
